adder_seq_ctrl: RTL and testbench



---
 rtl/adder_seq_ctrl_pkg.sv | 28 ++
 rtl/adder_seq_ctrl_slice.sv | 15 +
 rtl/adder_seq_ctrl.sv | 111 +++++++++++
 tb/tb_adder_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the slice-serial adder: FSM encoding and width helpers.
// Imported by the controller and by anything that observes its debug state.
package adder_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 for elaboration-time sizing; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Slice counter width: a single slice still gets a 1-bit counter.
    function automatic int cnt_width(input int slices);
        return (slices > 1) ? clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_slice.sv
// Purely combinational n-bit ripple adder slice with carry in/out.
// Any adder architecture with the same ports can replace this body.
module adder_slice #(
    parameter int n = 8
) (
    input  logic         cin,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Slice-serial w-bit adder: one shared n-bit adder_slice is reused k times,
// one slice per clock, with the carry held in a register between passes.
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int n = 8,
    parameter int k = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [n*k-1:0] a,
    input  logic [n*k-1:0] b,
    input  logic           cin,
    output logic           ready,
    output logic           done,
    output logic [n*k-1:0] s,
    output logic           cout,
    output logic           ovf,
    output state_t         state
);

    localparam int w  = n * k;
    localparam int cw = cnt_width(k);
    localparam logic [cw-1:0] last_cnt = cw'(k - 1);
    localparam logic [w-1:0]  slice_ones = w'({n{1'b1}});

    logic [w-1:0]  a_reg;
    logic [w-1:0]  b_reg;
    logic [cw-1:0] cnt;
    logic          carry;

    logic [31:0]   base;
    logic [n-1:0]  slice_a;
    logic [n-1:0]  slice_b;
    logic [n-1:0]  slice_s;
    logic          slice_cout;
    logic          msb_carry_in;
    logic [w-1:0]  s_merged;

    // Slice mux: shifting keeps the select free of variable part-select widths.
    always_comb begin
        base         = 32'(cnt) * 32'(n);
        slice_a      = n'(a_reg >> base);
        slice_b      = n'(b_reg >> base);
        msb_carry_in = slice_a[n-1] ^ slice_b[n-1] ^ slice_s[n-1];
        s_merged     = (s & ~(slice_ones << base)) | (w'(slice_s) << base);
    end

    adder_slice #(
        .n(n)
    ) u_slice (
        .cin (carry),
        .a   (slice_a),
        .b   (slice_b),
        .s   (slice_s),
        .cout(slice_cout)
    );

    // Handshake: a request is accepted on any rising edge where start=1 and
    // ready=1; ready is low only in RUN, so start during RUN is simply dropped.
    // done is high for exactly the one cycle spent in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                        ready <= 1'b0;
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    s     <= s_merged;
                    carry <= slice_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == last_cnt) begin
                        cout  <= slice_cout;
                        ovf   <= msb_carry_in ^ slice_cout;
                        state <= DONE;
                        ready <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl (n=8, k=4): directed scenarios plus
// a randomized back-to-back stream checked against a plain-arithmetic model.
module tb_adder_seq_ctrl;
    import adder_seq_ctrl_pkg::*;

    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;
    localparam int NRAND = 12000;
    localparam int MAXWAIT = 4 * K + 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    state_t       st;

    int total = 0;
    int bad = 0;
    logic [W+1:0] exp_q[$];

    always #5 clk = ~clk;

    adder_seq_ctrl #(.n(N), .k(K)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .ready(ready),
        .done (done),
        .s    (s),
        .cout (cout),
        .ovf  (ovf),
        .state(st)
    );

    // Reference: full-width sum; overflow when same-signed operands give a sum of the other sign.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        logic [W:0]   full;
        logic [W-1:0] sum;
        logic         ov;
        full = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        sum  = full[W-1:0];
        ov   = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
        return {ov, full[W], sum};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, issues one request, scrambles the inputs, and
    // returns edges from accept to done, or -1 when done never arrives.
    task automatic do_req(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rc,
                          output int lat);
        for (int i = 0; i < MAXWAIT && ready !== 1'b1; i++) tick();
        a = ra;
        b = rb;
        cin = rc;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom_range(0, 1));
        lat = -1;
        for (int i = 1; i <= MAXWAIT; i++) begin
            tick();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        #2;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (s !== '0) begin bad++; $display("FAIL reset_s got=%h want=0", s); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        total++; if (st !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=0", st); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL post_reset_flags got=%b%b want=10", ready, done); end
    endtask

    task automatic test_vectors();
        int lat;
        do_req(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, lat);
        total++; if (lat != K) begin bad++; $display("FAIL v1_latency got=%0d want=%0d", lat, K); end
        total++; if (s !== 32'h0000_0000) begin bad++; $display("FAIL v1_s got=%h want=00000000", s); end
        total++; if (cout !== 1'b1) begin bad++; $display("FAIL v1_cout got=%b want=1", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL v1_ovf got=%b want=0", ovf); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL v1_pulse_width got=%b want=0", done); end
        do_req(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        total++; if (lat != K) begin bad++; $display("FAIL v2_latency got=%0d want=%0d", lat, K); end
        total++; if (s !== 32'h8000_0000) begin bad++; $display("FAIL v2_s got=%h want=80000000", s); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL v2_cout got=%b want=0", cout); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL v2_ovf got=%b want=1", ovf); end
        tick();
        tick();
        tick();
        total++; if (s !== 32'h8000_0000 || ovf !== 1'b1 || cout !== 1'b0) begin
            bad++; $display("FAIL hold_outputs got=%h/%b/%b want=80000000/0/1", s, cout, ovf);
        end
        total++; if (ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL idle_flags got=%b%b want=10", ready, done); end
    endtask

    task automatic test_start_in_run();
        int dones;
        int lat;
        a = 32'd1;
        b = 32'd2;
        cin = 1'b0;
        start = 1'b1;
        tick();
        a = 32'hAA;
        b = 32'h55;
        cin = 1'b1;
        dones = 0;
        lat = -1;
        for (int i = 1; i <= K; i++) begin
            tick();
            if (done === 1'b1) begin
                dones++;
                if (lat < 0) lat = i;
            end
        end
        start = 1'b0;
        total++; if (lat != K) begin bad++; $display("FAIL run_start_latency got=%0d want=%0d", lat, K); end
        total++; if (s !== 32'h0000_0003) begin bad++; $display("FAIL run_start_s got=%h want=00000003", s); end
        total++; if (cout !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL run_start_flags got=%b%b want=00", cout, ovf); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total++; if (dones != 1) begin bad++; $display("FAIL run_start_done_count got=%0d want=1", dones); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        logic         c1, c2;
        logic [W+1:0] e1, e2;
        int           lat;
        a1 = $urandom; b1 = $urandom; c1 = 1'($urandom_range(0, 1));
        a2 = $urandom; b2 = $urandom; c2 = 1'($urandom_range(0, 1));
        e1 = ref_add(a1, b1, c1);
        e2 = ref_add(a2, b2, c2);
        do_req(a1, b1, c1, lat);
        total++; if (lat != K) begin bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, K); end
        total++; if ({ovf, cout, s} !== e1) begin bad++; $display("FAIL b2b_first_result got=%h want=%h", {ovf, cout, s}, e1); end
        a = a2;
        b = b2;
        cin = c2;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b%b want=00", ready, done); end
        lat = -1;
        for (int i = 1; i <= MAXWAIT; i++) begin
            tick();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        total++; if (lat != K) begin bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, K); end
        total++; if ({ovf, cout, s} !== e2) begin bad++; $display("FAIL b2b_second_result got=%h want=%h", {ovf, cout, s}, e2); end
        tick();
    endtask

    task automatic test_reset_abort();
        int dones;
        int lat;
        logic [W+1:0] e;
        a = 32'h1234_5678;
        b = 32'h1111_1111;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        total++; if (st !== RUN) begin bad++; $display("FAIL abort_in_run got=%0d want=1", st); end
        rst = 1'b1;
        #1;
        total++; if (s !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL abort_clear got=%h/%b/%b want=0/0/0", s, cout, ovf);
        end
        total++; if (ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL abort_flags got=%b%b want=10", ready, done); end
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
        e = ref_add(32'h89AB_CDEF, 32'h7654_3211, 1'b1);
        do_req(32'h89AB_CDEF, 32'h7654_3211, 1'b1, lat);
        total++; if (lat != K) begin bad++; $display("FAIL abort_next_latency got=%0d want=%0d", lat, K); end
        total++; if ({ovf, cout, s} !== e) begin bad++; $display("FAIL abort_next_result got=%h want=%h", {ovf, cout, s}, e); end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W+1:0] e;
        int           lat;
        for (int i = 0; i < NRAND; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if ((i % 8) == 0) ra[W-1] = rb[W-1];
            exp_q.push_back(ref_add(ra, rb, rc));
            do_req(ra, rb, rc, lat);
            e = exp_q.pop_front();
            total++; if (lat != K) begin
                bad++; $display("FAIL rand_latency idx=%0d got=%0d want=%0d", i, lat, K);
                break;
            end
            total++; if (s !== e[W-1:0]) begin
                bad++; if (bad < 20) $display("FAIL rand_s idx=%0d got=%h want=%h", i, s, e[W-1:0]);
            end
            total++; if (cout !== e[W]) begin
                bad++; if (bad < 20) $display("FAIL rand_cout idx=%0d got=%b want=%b", i, cout, e[W]);
            end
            total++; if (ovf !== e[W+1]) begin
                bad++; if (bad < 20) $display("FAIL rand_ovf idx=%0d got=%b want=%b", i, ovf, e[W+1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_in_run();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
